// File: rtl/mips_writeback_unit_pkg.sv
// Shared types for the MIPS writeback unit: load kind codes, queue entry layout
// and the default queue depth.
package mips_wb_pkg;

    localparam int WB_QUEUE_DEPTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LB  = 3'd1,
        LBU = 3'd2,
        LH  = 3'd3,
        LHU = 3'd4,
        LWL = 3'd5,
        LWR = 3'd6
    } load_kind_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mips_writeback_unit_if.sv
// Request/handshake and register-file write bundle for the writeback unit.
interface mips_wb_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_dest;
    logic [2:0]  load_kind;
    logic [1:0]  load_addr_lo;
    logic [31:0] load_word;
    logic [31:0] load_rt_old;
    logic        wb_hold;
    logic        write_enable;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [31:0] pending_mask;
    logic        queue_full;

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  load_valid, load_dest, load_kind, load_addr_lo, load_word, load_rt_old,
        input  wb_hold,
        output alu_ready, load_ready,
        output write_enable, write_register, write_data, pending_mask, queue_full
    );

    modport master (
        output alu_valid, alu_dest, alu_data,
        output load_valid, load_dest, load_kind, load_addr_lo, load_word, load_rt_old,
        output wb_hold,
        input  alu_ready, load_ready,
        input  write_enable, write_register, write_data, pending_mask, queue_full
    );
endinterface

// File: rtl/mips_writeback_unit_load_formatter.sv
// Combinational load-data formatter: byte/half extension and LWL/LWR merge
// against the old rt value, little-endian byte lanes.
module mips_load_formatter
    import mips_wb_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] r;
        r = b;
        return r;
    endfunction

    function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
        logic signed [31:0] r;
        r = h;
        return r;
    endfunction

    logic [7:0]  lane;
    logic [15:0] half;
    logic [4:0]  lwr_sh;
    logic [4:0]  lwl_sh;

    always_comb begin
        case (addr_lo)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
        // a[0] is deliberately ignored for halfword loads
        half   = addr_lo[1] ? word[31:16] : word[15:0];
        lwr_sh = {addr_lo, 3'b000};
        lwl_sh = {~addr_lo, 3'b000};

        result = word;
        case (load_kind_t'(kind))
            LB:      result = sext8(lane);
            LBU:     result = {24'd0, lane};
            LH:      result = sext16(half);
            LHU:     result = {16'd0, half};
            LWL:     result = (word << lwl_sh) | (rt_old & ((32'd1 << lwl_sh) - 32'd1));
            LWR:     result = (word >> lwr_sh) | (rt_old & ~(32'hFFFF_FFFF >> lwr_sh));
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mips_writeback_unit.sv
// Register-file write-port owner: arbitrates ALU/load writebacks into an in-order
// queue, drains it around hold cycles and exports the pending-destination mask.
module mips_writeback_unit
    import mips_wb_pkg::*;
#(
    parameter int QUEUE_DEPTH = WB_QUEUE_DEPTH_DEFAULT
)
(
    input  logic      clk,
    input  logic      reset,
    mips_wb_if.slave  bus
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        entry_q [QUEUE_DEPTH];
    wb_entry_t        entry_d [QUEUE_DEPTH];

    logic [31:0]      fmt_data;
    logic             full, empty;
    logic             load_acc, alu_acc, push, pop;
    wb_entry_t        push_entry, head_entry;
    logic [PTR_W-1:0] slot;
    logic [31:0]      pend;

    mips_load_formatter u_fmt (
        .kind    (bus.load_kind),
        .addr_lo (bus.load_addr_lo),
        .word    (bus.load_word),
        .rt_old  (bus.load_rt_old),
        .result  (fmt_data)
    );

    // Accept side: load has priority, at most one accept per edge, no bypass when full
    always_comb begin
        full           = (count_q == FULL_CNT);
        empty          = (count_q == '0);
        bus.queue_full = full;
        bus.load_ready = !full;
        bus.alu_ready  = !full && !bus.load_valid;
        load_acc       = bus.load_valid && !full;
        alu_acc        = bus.alu_valid && !full && !bus.load_valid;

        push_entry.dest = load_acc ? bus.load_dest : bus.alu_dest;
        push_entry.data = load_acc ? fmt_data : bus.alu_data;
        // r0 writes complete the handshake but never occupy a slot
        push = (load_acc || alu_acc) && (push_entry.dest != 5'd0);
    end

    always_comb begin
        head_entry         = entry_q[head_q];
        pop                = !empty && !bus.wb_hold;
        bus.write_enable   = pop;
        bus.write_register = empty ? 5'd0 : head_entry.dest;
        bus.write_data     = empty ? 32'd0 : head_entry.data;

        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        entry_d = entry_q;
        if (push) begin
            entry_d[tail_q] = push_entry;
        end
    end

    // Only slots within the live window contribute; stale payload is ignored
    always_comb begin
        pend = '0;
        slot = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                pend[entry_q[slot].dest] = 1'b1;
            end
        end
        pend[0]          = 1'b0;
        bus.pending_mask = pend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule
